pulse_handshake_tx: RTL
=======================

Name: pulse_handshake_tx

Overview:
- Source-side end of a req/ack pulse crossing. Accepts single-cycle event pulses in the clk2 domain and queues them.
- Delivers each queued event to a far domain as one full 4-phase request/acknowledge transaction.
- The far domain's pulse receiver consumes req_out and returns ack_in asynchronously.
- Placed wherever clk2 logic must send countable events to a domain of unknown frequency without losing any.

Parameters:
- SYNC_STAGES, 2, number of flops in the ack_in synchronizer chain (minimum 2).
- PEND_W, 4, width of the pending-event counter; at most 2**PEND_W-1 events queued.
- DROP_W, 8, width of the saturating dropped-event counter.
- TIMEOUT_CYC, 1024, clk2 cycles allowed in REQ before abort (optional feature only).

Ports:
- clk2  input  1  block clock; all state is in this domain.
- reset_in  input  1  asynchronous, active-high reset.
- pulse_in  input  1  event strobe, synchronous to clk2; one event per high cycle.
- ack_in  input  1  acknowledge level from far domain, asynchronous to clk2.
- ovf_clr  input  1  synchronous clear of overflow and drop_cnt.
- req_out  output  1  request level to far domain; driven directly from a flop.
- busy  output  1  high when the state is not IDLE or pending_cnt is non-zero.
- pending_cnt  output  PEND_W  events accepted but not yet acknowledged, including the one in flight.
- overflow  output  1  sticky; set when an event is dropped.
- drop_cnt  output  DROP_W  saturating count of dropped events.
- timeout  output  1  sticky abort flag; tied 0 when the optional feature is absent.

Behaviour:
- Reset: reset_in asynchronous, active-high; clock clk2. While reset is asserted:
  - req_out=0, busy=0, pending_cnt=0, overflow=0, drop_cnt=0, timeout=0.
  - State is IDLE and the synchronizer flops are 0.
- ack_in passes through SYNC_STAGES flops to produce ack_s. Only ack_s is used.
- State IDLE:
  - If pending_cnt!=0 and ack_s==0, go to REQ and set req_out=1 on that edge.
- State REQ:
  - req_out is held at 1.
  - When ack_s==1, clear req_out, decrement pending_cnt by 1, and go to WAIT_LOW.
- State WAIT_LOW:
  - req_out=0.
  - When ack_s==0, go to IDLE. A new request may start on the next edge.
- Latency:
  - A pulse_in high at edge N with the block idle and empty gives pending_cnt=1 after edge N.
  - req_out rises after edge N+1.
- Simultaneous pulse_in and decrement in the same cycle: pending_cnt is unchanged.
- Full queue:
  - Condition is pending_cnt==2**PEND_W-1 with pulse_in high and no decrement that cycle.
  - The event is dropped, overflow is set, and drop_cnt increments, saturating at 2**DROP_W-1.
  - pending_cnt does not change.
- Full queue with a decrement in the same cycle: the event is accepted and nothing is dropped.
- ovf_clr:
  - Clears overflow and drop_cnt on the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_cnt=1.
- Reset during REQ or WAIT_LOW: req_out falls immediately and the in-flight and queued events are discarded.
- pending_cnt never wraps below 0. A decrement happens only on the REQ->WAIT_LOW transition.
- An ack_s rise outside REQ is ignored.

Optional Feature:
- Macro: PULSE_HANDSHAKE_TX_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to REQ and counts every cycle spent in REQ.
  - When it reaches TIMEOUT_CYC-1 with ack_s still 0, the block clears req_out, decrements pending_cnt, sets timeout (sticky, cleared by ovf_clr), and goes to WAIT_LOW.
  - An ack_s rise on the same cycle takes priority and is a normal completion with no timeout.
- Undefined:
  - No counter is built and the block waits in REQ indefinitely.
  - timeout is tied to 0 and TIMEOUT_CYC is unused.

Decomposition:
- Package pulse_handshake_pkg:
  - state encoding typedef (IDLE, REQ, WAIT_LOW);
  - default widths as localparams;
  - a saturating-increment function shared by drop_cnt.
- Sub-module sync_chain: an SYNC_STAGES-deep flop chain on clk2, with asynchronous reset from reset_in, used for ack_in.

Test Plan:
- Single event: one pulse_in; far-domain model asserts ack 3 cycles after req and drops it 2 cycles after req falls. Required:
  - req_out rises 2 cycles after the pulse;
  - one transaction only;
  - pending_cnt goes 1 then 0;
  - busy falls after WAIT_LOW exits.
- Burst: 20 back-to-back pulse_in with PEND_W=4 and a slow ack. Required: pending_cnt saturates at 15, drop_cnt=5, overflow=1, and exactly 15 req transactions complete.
- Simultaneity: pulse_in on the same cycle as REQ->WAIT_LOW with pending_cnt=15. Required: pending_cnt stays 15 and drop_cnt is unchanged.
- Reset mid-transaction: assert reset_in while in REQ. Required: req_out is 0 within the same cycle (asynchronous), and all outputs take their reset values before the next edge.
- ovf_clr: assert ovf_clr with no drop, then ovf_clr together with a drop. Required: first case gives overflow=0 and drop_cnt=0; second gives overflow=1 and drop_cnt=1.
- Timeout (macro defined, TIMEOUT_CYC=16): the ack never arrives. Required: req_out falls after 16 cycles in REQ, timeout=1, pending_cnt is decremented, and the next event starts a new request once ack_s==0.

Source files
------------

// File: rtl/pulse_handshake_pkg.sv
// pulse_handshake_pkg: FSM encoding, default widths and saturating increment
// shared by pulse_handshake_tx and its synchronizer.
package pulse_handshake_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_REQ      = 2'd1;
    localparam state_t ST_WAIT_LOW = 2'd2;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_PEND_W      = 4;
    localparam int DEF_DROP_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 1024;
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v == max_v) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/pulse_handshake_tx_sync_chain.sv
// sync_chain: STAGES-deep flop chain bringing an asynchronous level into clk2.
module sync_chain
    import pulse_handshake_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk2,
    input  logic reset_in,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[STAGES-2:0], d};
    always_ff @(posedge clk2 or posedge reset_in) begin
        if (reset_in) sync_q <= '0;
        else sync_q <= sync_d;
    end
    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/pulse_handshake_tx.sv
// pulse_handshake_tx: queues clk2 event pulses and sends each as a 4-phase req/ack transaction.
// Define PULSE_HANDSHAKE_TX_TIMEOUT_EN to abort requests left unacknowledged for TIMEOUT_CYC cycles.
module pulse_handshake_tx
    import pulse_handshake_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int PEND_W      = DEF_PEND_W,
    parameter int DROP_W      = DEF_DROP_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk2,
    input  logic              reset_in,
    input  logic              pulse_in,
    input  logic              ack_in,
    input  logic              ovf_clr,
    output logic              req_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending_cnt,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              timeout
);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;
    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              ack_s, expire, dec, drop, accept;
    sync_chain #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk2     (clk2),
        .reset_in (reset_in),
        .d        (ack_in),
        .q        (ack_s)
    );
`ifdef PULSE_HANDSHAKE_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    // A same-cycle ack_s wins over expiry, so a late ack is still a normal completion.
    assign expire = state_q == ST_REQ && !ack_s && cnt_q == CNT_W'(TIMEOUT_CYC - 1);
    always_comb begin
        cnt_d = (state_q == ST_REQ) ? cnt_q + CNT_W'(1) : '0;
        tmo_d = expire ? 1'b1 : ovf_clr ? 1'b0 : tmo_q;
    end
    always_ff @(posedge clk2 or posedge reset_in) begin
        if (reset_in) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
    assign timeout = tmo_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = |TIMEOUT_CYC;
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        dec     = 1'b0;
        if (state_q == ST_IDLE && pend_q != '0 && !ack_s) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
        end else if (state_q == ST_REQ && (ack_s || expire)) begin
            state_d = ST_WAIT_LOW;
            req_d   = 1'b0;
            dec     = 1'b1;
        end else if (state_q == ST_WAIT_LOW && !ack_s) begin
            state_d = ST_IDLE;
        end
        // A completing transaction frees a slot in the same cycle, so a full queue can still accept.
        drop   = pulse_in && pend_q == PEND_MAX && !dec;
        accept = pulse_in && !drop;
        pend_d = pend_q + PEND_W'(accept) - PEND_W'(dec);
        ovf_d  = drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
        drop_d = drop ? (ovf_clr ? DROP_W'(1) : DROP_W'(sat_inc(32'(drop_q), 32'(DROP_MAX))))
                      : ovf_clr ? '0 : drop_q;
    end
    always_ff @(posedge clk2 or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end
    assign req_out     = req_q;
    assign busy        = state_q != ST_IDLE || pend_q != '0;
    assign pending_cnt = pend_q;
    assign overflow    = ovf_q;
    assign drop_cnt    = drop_q;
endmodule
